// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send,
// shifts one command byte out on device clock edges and checks the device ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       done,
  output logic       err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_data, w_data_nxt;
  logic [INH_W-1:0] r_inh_cnt, w_inh_nxt;
  logic [TO_W-1:0]  r_to_cnt, w_to_nxt;
  logic [3:0]       r_edge_cnt, w_edge_nxt;
  logic             r_drive, w_drive_nxt;

  logic r_clk_meta, r_clk_sync, r_clk_prev;
  logic r_dat_meta, r_dat_sync;

  logic       w_fall;
  logic       w_timeout;
  logic [3:0] w_edge_inc;
  logic [2:0] w_bit_idx;

  // Idle level of an open-drain line is high, so the synchronizers reset to 1
  // and no false falling edge is seen right after reset.
  // NOTE: async-reset flops use non-blocking assignments only; blocking ones
  // here would create ordering races between the flops of the same edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_clk_meta <= 1'b1;
      r_clk_sync <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_meta <= 1'b1;
      r_dat_sync <= 1'b1;
    end else begin
      r_clk_meta <= ps2_clk_in;
      r_clk_sync <= r_clk_meta;
      r_clk_prev <= r_clk_sync;
      r_dat_meta <= ps2_data_in;
      r_dat_sync <= r_dat_meta;
    end
  end

  assign w_fall     = r_clk_prev & ~r_clk_sync;
  assign w_edge_inc = r_edge_cnt + 4'd1;
  assign w_bit_idx  = w_edge_inc[2:0] - 3'd1;
  assign w_timeout  = (r_state inside {S_REQ, S_SEND, S_ACK, S_WAIT_IDLE}) &&
                      (r_to_cnt == TO_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_data     <= '0;
      r_inh_cnt  <= '0;
      r_to_cnt   <= '0;
      r_edge_cnt <= '0;
      r_drive    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_data     <= w_data_nxt;
      r_inh_cnt  <= w_inh_nxt;
      r_to_cnt   <= w_to_nxt;
      r_edge_cnt <= w_edge_nxt;
      r_drive    <= w_drive_nxt;
    end
  end

  // Outputs are decoded from registered state, so the oe lines drop the
  // instant the state register is reset.
  // NOTE: every signal gets a default before the case; a path that leaves one
  // unassigned would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_inh_nxt   = r_inh_cnt;
    w_to_nxt    = r_to_cnt;
    w_edge_nxt  = r_edge_cnt;
    w_drive_nxt = r_drive;
    tx_ready    = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;

    case (r_state)
      S_IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          w_data_nxt  = tx_data;
          w_inh_nxt   = '0;
          w_state_nxt = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (r_inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
          // Start bit overlaps the last inhibit cycle.
          ps2_data_oe = 1'b1;
          w_to_nxt    = '0;
          w_edge_nxt  = '0;
          w_drive_nxt = 1'b1;
          w_state_nxt = S_REQ;
        end else begin
          w_inh_nxt = r_inh_cnt + INH_W'(1);
        end
      end

      S_REQ, S_SEND, S_ACK, S_WAIT_IDLE: begin
        if (w_timeout) begin
          err         = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_to_nxt = r_to_cnt + TO_W'(1);
          case (r_state)
            S_REQ: begin
              ps2_data_oe = 1'b1;
              if (w_fall) begin
                w_edge_nxt  = 4'd1;
                w_drive_nxt = ~r_data[0];
                w_state_nxt = S_SEND;
              end
            end
            S_SEND: begin
              ps2_data_oe = r_drive;
              if (w_fall) begin
                w_edge_nxt = w_edge_inc;
                if (w_edge_inc <= 4'd8) begin
                  w_drive_nxt = ~r_data[w_bit_idx];
                end else if (w_edge_inc == 4'd9) begin
                  // Odd parity bit is ~^data; driving low means oe = ^data.
                  w_drive_nxt = ^r_data;
                end else begin
                  w_drive_nxt = 1'b0;
                  w_state_nxt = S_ACK;
                end
              end
            end
            S_ACK: begin
              ps2_data_oe = r_drive;
              if (w_fall) begin
                if (!r_dat_sync) begin
                  w_state_nxt = S_WAIT_IDLE;
                end else begin
                  err         = 1'b1;
                  w_state_nxt = S_IDLE;
                end
              end
            end
            default: begin
              ps2_data_oe = r_drive;
              if (r_clk_sync && r_dat_sync) begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
              end
            end
          endcase
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device on the
// open-drain lines (device clock period 40 system cycles).
module tb_ps2_host_tx;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, done, err;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk, dev_data;
  logic       w_ps2_clk, w_ps2_data;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  int n_err   = 0;
  int n_both  = 0;
  int cyc     = 0;

  logic [9:0] m_bits;
  int         m_inh, m_start;
  bit         m_rdy_hi, m_done_seen, m_err_seen, m_fin, m_err_prev, m_rdy_after_err;

  assign w_ps2_clk  = ps2_clk_oe  ? 1'b0 : dev_clk;
  assign w_ps2_data = ps2_data_oe ? 1'b0 : dev_data;

  ps2_host_tx #(.INHIBIT_CYCLES(8), .TIMEOUT_CYCLES(2000)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .done       (done),
    .err        (err),
    .ps2_clk_in (w_ps2_clk),
    .ps2_data_in(w_ps2_data),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) n_done <= n_done + 1;
    if (err)  n_err  <= n_err + 1;
    if (done && err) n_both <= n_both + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_send(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic obs();
    if (m_err_prev) m_rdy_after_err = tx_ready;
    m_err_prev = err;
    if (!m_fin) m_rdy_hi |= tx_ready;
    if (done) m_done_seen = 1'b1;
    if (err)  m_err_seen  = 1'b1;
    if (done || err) m_fin = 1'b1;
  endtask

  // Device side of one transfer. abort_edge>0 returns mid-low-phase of that
  // edge with the device clock still low; inj_edge>0 pulses tx_valid then.
  task automatic dev_xfer(input bit ack, input int abort_edge, input int inj_edge,
                          input bit drop_valid);
    int n;
    m_bits = '0; m_inh = 0; m_start = 0; m_rdy_hi = 0;
    m_done_seen = 0; m_err_seen = 0; m_fin = 0; m_err_prev = 0; m_rdy_after_err = 0;
    n = 0;
    while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && n < 100) begin
      if (ps2_clk_oe) m_inh++;
      if (ps2_clk_oe && ps2_data_oe) m_start++;
      m_rdy_hi |= tx_ready & ps2_clk_oe;
      @(negedge clk);
      n++;
    end
    check("req_seen", 32'(n < 100), 32'd1);
    if (n >= 100) return;
    if (drop_valid) tx_valid = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      for (int c = 0; c < 20; c++) begin
        if (k == 11 && c == 10 && ack) dev_data = 1'b0;
        obs();
        @(negedge clk);
      end
      dev_clk = 1'b0;
      for (int c = 0; c < 20; c++) begin
        if (c == 15 && k <= 10) m_bits[k-1] = w_ps2_data;
        if (c == 16 && k == abort_edge) return;
        if (k == inj_edge && c == 5) begin
          tx_data  = 8'h00;
          tx_valid = 1'b1;
        end
        if (k == inj_edge && c == 6) tx_valid = 1'b0;
        obs();
        @(negedge clk);
      end
      dev_clk = 1'b1;
    end
    dev_data = 1'b1;
    for (int c = 0; c < 40 && !m_fin; c++) begin
      @(negedge clk);
      obs();
    end
  endtask

  initial begin
    int d0, e0, n, t0;
    rstn = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; dev_clk = 1'b1; dev_data = 1'b1;
    #12;
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge clk); rstn = 1'b1;
    repeat (3) @(negedge clk);

    // 0xED with device ACK
    d0 = n_done; e0 = n_err;
    start_send(8'hED);
    dev_xfer(1'b1, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    check("ed_bits", 32'(m_bits), 32'h3ED);
    check("ed_inhibit_cycles", 32'(m_inh), 32'd8);
    check("ed_start_cycles", 32'(m_start), 32'd1);
    check("ed_ready_busy", 32'(m_rdy_hi), 32'd0);
    check("ed_done_cnt", 32'(n_done - d0), 32'd1);
    check("ed_err_cnt", 32'(n_err - e0), 32'd0);

    // back-to-back 0x01 then 0xFF with tx_valid held
    d0 = n_done; e0 = n_err;
    @(negedge clk); tx_data = 8'h01; tx_valid = 1'b1;
    @(negedge clk); tx_data = 8'hFF;
    dev_xfer(1'b1, 0, 0, 1'b0);
    check("b2b0_bits", 32'(m_bits), 32'h201);
    check("b2b0_ready_busy", 32'(m_rdy_hi), 32'd0);
    dev_xfer(1'b1, 0, 0, 1'b1);
    check("b2b1_bits", 32'(m_bits), 32'h3FF);
    check("b2b1_ready_busy", 32'(m_rdy_hi), 32'd0);
    check("b2b1_inhibit_cycles", 32'(m_inh), 32'd8);
    repeat (2) @(negedge clk);
    check("b2b_done_cnt", 32'(n_done - d0), 32'd2);
    check("b2b_err_cnt", 32'(n_err - e0), 32'd0);
    check("b2b_idle_ready", 32'(tx_ready), 32'd1);

    // NACK: device leaves data high at edge 11
    d0 = n_done; e0 = n_err;
    start_send(8'h3C);
    dev_xfer(1'b0, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    check("nack_bits", 32'(m_bits), 32'h33C);
    check("nack_err_cnt", 32'(n_err - e0), 32'd1);
    check("nack_done_cnt", 32'(n_done - d0), 32'd0);
    check("nack_idle_next", 32'(m_rdy_after_err), 32'd1);

    // timeout: device never clocks
    d0 = n_done; e0 = n_err;
    start_send(8'h96);
    n = 0;
    while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && n < 100) begin
      @(negedge clk); n++;
    end
    check("to_req_seen", 32'(n < 100), 32'd1);
    t0 = cyc;
    n = 0;
    while (!err && n < 2100) begin
      @(negedge clk); n++;
    end
    check("to_err_seen", 32'(err), 32'd1);
    check("to_latency", 32'(cyc - t0), 32'd2000);
    check("to_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("to_data_oe", 32'(ps2_data_oe), 32'd0);
    @(negedge clk);
    check("to_idle_next", 32'(tx_ready), 32'd1);
    check("to_done_cnt", 32'(n_done - d0), 32'd0);

    // reset during SEND after edge 4
    d0 = n_done; e0 = n_err;
    start_send(8'h00);
    dev_xfer(1'b1, 4, 0, 1'b0);
    check("rs_bits_lo", 32'(m_bits[3:0]), 32'h0);
    check("rs_pre_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("rs_pre_data_oe", 32'(ps2_data_oe), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("rs_async_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("rs_async_data_oe", 32'(ps2_data_oe), 32'd0);
    dev_clk = 1'b1; dev_data = 1'b1;
    @(negedge clk); rstn = 1'b1;
    repeat (3) @(negedge clk);
    check("rs_ready_after", 32'(tx_ready), 32'd1);
    check("rs_no_done", 32'(n_done - d0), 32'd0);
    d0 = n_done; e0 = n_err;
    start_send(8'h55);
    dev_xfer(1'b1, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    check("rs_55_bits", 32'(m_bits), 32'h355);
    check("rs_55_done_cnt", 32'(n_done - d0), 32'd1);
    check("rs_55_err_cnt", 32'(n_err - e0), 32'd0);

    // tx_valid pulsed during SEND is ignored
    d0 = n_done; e0 = n_err;
    start_send(8'hA5);
    dev_xfer(1'b1, 0, 3, 1'b0);
    repeat (30) @(negedge clk);
    check("inj_bits", 32'(m_bits), 32'h3A5);
    check("inj_done_cnt", 32'(n_done - d0), 32'd1);
    check("inj_err_cnt", 32'(n_err - e0), 32'd0);
    check("inj_no_restart", 32'(ps2_clk_oe), 32'd0);
    check("inj_idle", 32'(tx_ready), 32'd1);

    check("done_err_exclusive", 32'(n_both), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 5000, SHALL set the clk cycles ps2_clk is held low before the request (100 us at 50 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 750000, SHALL set the maximum clk cycles from clock release to bus idle (15 ms at 50 MHz).
REQ-003 clk  in  1  system clock; all state SHALL update on its rising edge.
REQ-004 rstn  in  1  reset; asynchronous, active-low.
REQ-005 tx_data  in  8  command byte to send to the PS/2 device.
REQ-006 tx_valid  in  1  request; a byte is accepted on a cycle with tx_valid=1 and tx_ready=1.
REQ-007 tx_ready  out  1  high only in IDLE.
REQ-008 done  out  1  one-cycle pulse when a transfer finishes with a valid device ACK.
REQ-009 err  out  1  one-cycle pulse on NACK or timeout.
REQ-010 ps2_clk_in  in  1  sampled level of the open-drain PS/2 clock line.
REQ-011 ps2_data_in  in  1  sampled level of the open-drain PS/2 data line.
REQ-012 ps2_clk_oe  out  1  1 = drive PS/2 clock low; 0 = release.
REQ-013 ps2_data_oe  out  1  1 = drive PS/2 data low; 0 = release.

Function
REQ-014 ps2_clk_in and ps2_data_in SHALL each pass through a 2-flop synchronizer; a device-clock falling edge SHALL be one cycle where the synchronized clock goes from 1 to 0.
REQ-015 States SHALL be IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE.
REQ-016 IDLE: all oe outputs 0, tx_ready=1; on acceptance, tx_data SHALL be latched and the state SHALL be INHIBIT in the next cycle.
REQ-017 INHIBIT SHALL last exactly INHIBIT_CYCLES cycles with ps2_clk_oe=1; ps2_data_oe SHALL be 1 in its final cycle only (start bit).
REQ-018 REQ: ps2_clk_oe=0, ps2_data_oe=1; start the timeout counter; the first falling edge SHALL drive bit 0 and move to SEND.
REQ-019 SEND: a 4-bit edge counter SHALL count falling edges 1..10; edge k (1..8) drives data bit k-1 (LSB first), edge 9 drives odd parity (~^tx_data), and edge 10 drives stop (ps2_data_oe=0) and moves to ACK.
REQ-020 Driven value rule: ps2_data_oe = ~bit; ps2_data_oe SHALL change only in the cycle after a detected falling edge.
REQ-021 ACK: on falling edge 11, synchronized data 0 SHALL move to WAIT_IDLE; data 1 SHALL pulse err and return to IDLE.
REQ-022 WAIT_IDLE: when both synchronized lines are 1, done SHALL pulse and the state SHALL return to IDLE in the same cycle.
REQ-023 Timeout: if the counter reaches TIMEOUT_CYCLES in REQ, SEND, ACK or WAIT_IDLE, all oe outputs SHALL be 0, err SHALL pulse, and the state SHALL be IDLE next cycle.
REQ-024 done and err SHALL never be high together; tx_valid outside IDLE SHALL be ignored with no effect.
REQ-025 Back-to-back: a tx_valid held high SHALL be accepted in the first IDLE cycle after done/err.

Reset
REQ-026 rstn low SHALL force IDLE asynchronously with ps2_clk_oe=0, ps2_data_oe=0, done=0, err=0, tx_ready=1, counters and synchronizers cleared (synchronizers to 1).
REQ-027 Reset mid-transfer SHALL release both lines immediately and discard the byte; there is no resume.

Verification (INHIBIT_CYCLES=8, TIMEOUT_CYCLES=2000, device model clock period 40 cycles)
REQ-028 Send 0xED, device ACKs -> clk_oe low 8 cycles; data bits 1,0,1,1,0,1,1,1, parity 1, stop; done pulse; err 0.
REQ-029 Send 0x01 then 0xFF back-to-back with tx_valid held -> parity 0 then 1; two done pulses; tx_ready low throughout each transfer.
REQ-030 Device leaves data high at edge 11 -> err pulse, no done; IDLE next cycle.
REQ-031 Device never clocks after request -> err exactly 2000 cycles after REQ entry; both oe 0.
REQ-032 rstn low during SEND after edge 4 -> both oe 0 asynchronously; after release tx_ready=1 and the next send of 0x55 completes correctly.
REQ-033 Pulse tx_valid during SEND -> ignored; the in-flight byte is unchanged and only one done pulse occurs.
